// File: rtl/neptune_dma_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : neptune_dma_pkg
//  Purpose  : Shared definitions for the Neptune I DMA interface.
//             Holds the we_in command codes (the control matrix decodes the
//             same values) and the dma_loader FSM state encoding.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package neptune_dma_pkg;

  // Write-enable command codes driven onto the core we_in pins
  localparam logic [2:0] WE_NONE = 3'b000;
  localparam logic [2:0] WE_RF   = 3'b001;
  localparam logic [2:0] WE_RAM  = 3'b011;
  localparam logic [2:0] WE_PC   = 3'b100;
  localparam logic [2:0] WE_MAR  = 3'b101;

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_REQ       = 4'd1,
    S_SET_MAR   = 4'd2,
    S_WAIT_WORD = 4'd3,
    S_WR_RAM    = 4'd4,
    S_INCR      = 4'd5,
    S_SET_PC    = 4'd6,
    S_RELEASE   = 4'd7,
    S_FINISH    = 4'd8
  } state_e;

  // States in which the processor is held in DMA mode and approval must
  // stay asserted.
  function automatic logic in_dma_window(input state_e s);
    return (s == S_SET_MAR) || (s == S_WAIT_WORD) || (s == S_WR_RAM) ||
           (s == S_INCR)    || (s == S_SET_PC);
  endfunction

endpackage
`default_nettype wire

// File: rtl/dma_loader.sv
`default_nettype none
// ============================================================================
//  Module   : dma_loader
//  Purpose  : DMA initiator for Neptune I. On start it requests DMA mode,
//             sets MAR to the base address, streams words from a valid/ready
//             source into RAM (write + MAR increment per word), writes the
//             entry PC and then releases the core through a reset cycle.
//  Ports    : clk, rst            - clock, synchronous active-high reset
//             start               - load request (sampled in IDLE only)
//             base_addr, entry_pc - first RAM address / final PC value
//             word_count          - number of words to load
//             s_data/s_valid/s_ready - word source handshake
//             dma_appr, dma_req   - DMA approval / request
//             cpu_rst             - core reset (high with dma_req = DMA mode)
//             we_out, mar_incr    - DMA command to the core
//             dma_data            - data/address for the core write bus
//             busy, done, err     - status
//  Revision : 1.0 - initial release
// ============================================================================
module dma_loader
  import neptune_dma_pkg::*;
#(
  parameter int WIDTH        = 16,
  parameter int CNT_WIDTH    = 16,
  parameter int APPR_TIMEOUT = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     base_addr,
  input  logic [WIDTH-1:0]     entry_pc,
  input  logic [CNT_WIDTH-1:0] word_count,
  input  logic [WIDTH-1:0]     s_data,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic                 dma_appr,
  output logic                 dma_req,
  output logic                 cpu_rst,
  output logic [2:0]           we_out,
  output logic                 mar_incr,
  output logic [WIDTH-1:0]     dma_data,
  output logic                 busy,
  output logic                 done,
  output logic                 err
);

  localparam int                c_tmr_w    = $clog2(APPR_TIMEOUT + 1);
  localparam logic [c_tmr_w-1:0] c_tmr_last = c_tmr_w'(APPR_TIMEOUT - 1);
  localparam logic [c_tmr_w-1:0] c_tmr_one  = c_tmr_w'(1);
  localparam logic [CNT_WIDTH-1:0] c_cnt_one = CNT_WIDTH'(1);

  state_e                 state_q, state_d;
  logic                   gap_q, gap_d;
  logic [c_tmr_w-1:0]     tmr_q, tmr_d;
  logic [CNT_WIDTH-1:0]   rem_q, rem_d;
  logic [WIDTH-1:0]       base_q, base_d;
  logic [WIDTH-1:0]       pc_q, pc_d;
  logic [WIDTH-1:0]       word_q, word_d;
  logic                   err_q, err_d;

  logic                   w_appr_lost;
  logic                   w_cmd_slot;

  // Approval dropped while the core is under our control.
  assign w_appr_lost = in_dma_window(state_q) & ~dma_appr;
  // A command may only be presented in the first half of a command/GAP pair,
  // and never once approval is gone.
  assign w_cmd_slot  = ~gap_q & dma_appr;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      gap_q   <= 1'b0;
      tmr_q   <= '0;
      rem_q   <= '0;
      base_q  <= '0;
      pc_q    <= '0;
      word_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      gap_q   <= gap_d;
      tmr_q   <= tmr_d;
      rem_q   <= rem_d;
      base_q  <= base_d;
      pc_q    <= pc_d;
      word_q  <= word_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    gap_d    = gap_q;
    tmr_d    = tmr_q;
    rem_d    = rem_q;
    base_d   = base_q;
    pc_d     = pc_q;
    word_d   = word_q;
    err_d    = err_q;

    s_ready  = 1'b0;
    dma_req  = 1'b0;
    cpu_rst  = 1'b0;
    we_out   = WE_NONE;
    mar_incr = 1'b0;
    dma_data = '0;
    done     = 1'b0;

    if (in_dma_window(state_q) || state_q == S_REQ) begin
      dma_req = 1'b1;
      cpu_rst = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          base_d  = base_addr;
          pc_d    = entry_pc;
          rem_d   = word_count;
          tmr_d   = '0;
          gap_d   = 1'b0;
          err_d   = 1'b0;
          state_d = S_REQ;
        end
      end

      S_REQ: begin
        if (dma_appr) begin
          state_d = S_SET_MAR;
        end else if (tmr_q == c_tmr_last) begin
          err_d   = 1'b1;
          state_d = S_RELEASE;
        end else begin
          tmr_d = tmr_q + c_tmr_one;
        end
      end

      S_SET_MAR: begin
        dma_data = base_q;
        if (w_cmd_slot) we_out = WE_MAR;
        gap_d = ~gap_q;
        if (gap_q) state_d = (rem_q == '0) ? S_SET_PC : S_WAIT_WORD;
      end

      S_WAIT_WORD: begin
        // Gated by approval so a word is never consumed on the abort cycle.
        s_ready = dma_appr;
        if (s_valid && dma_appr) begin
          word_d  = s_data;
          state_d = S_WR_RAM;
        end
      end

      S_WR_RAM: begin
        dma_data = word_q;
        if (w_cmd_slot) we_out = WE_RAM;
        gap_d = ~gap_q;
        if (gap_q) state_d = S_INCR;
      end

      S_INCR: begin
        if (w_cmd_slot) begin
          mar_incr = 1'b1;
          rem_d    = rem_q - c_cnt_one;
        end
        gap_d = ~gap_q;
        // rem_q already holds the decremented count during the GAP cycle.
        if (gap_q) state_d = (rem_q != '0) ? S_WAIT_WORD : S_SET_PC;
      end

      S_SET_PC: begin
        dma_data = pc_q;
        if (w_cmd_slot) we_out = WE_PC;
        gap_d = ~gap_q;
        if (gap_q) state_d = S_RELEASE;
      end

      S_RELEASE: begin
        // dma_req low with cpu_rst high: the core runs its reset branch.
        cpu_rst = 1'b1;
        state_d = S_FINISH;
      end

      S_FINISH: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (w_appr_lost) begin
      err_d   = 1'b1;
      gap_d   = 1'b0;
      state_d = S_RELEASE;
    end
  end

  assign busy = (state_q != S_IDLE);
  assign err  = err_q;

endmodule
`default_nettype wire

// File: tb/tb_dma_loader.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_dma_loader
//  Purpose  : Self-checking bench for dma_loader. Load scenarios come from a
//             vector table; the expected DMA command stream is queued when a
//             scenario starts and popped by a monitor as commands appear.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_dma_loader;
  import neptune_dma_pkg::*;

  localparam int W  = 16;
  localparam int CW = 16;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [W-1:0]  base_addr;
  logic [W-1:0]  entry_pc;
  logic [CW-1:0] word_count;
  logic [W-1:0]  s_data;
  logic          s_valid;
  logic          s_ready;
  logic          dma_appr;
  logic          dma_req;
  logic          cpu_rst;
  logic [2:0]    we_out;
  logic          mar_incr;
  logic [W-1:0]  dma_data;
  logic          busy;
  logic          done;
  logic          err;

  always #5 clk = ~clk;

  dma_loader #(.WIDTH(W), .CNT_WIDTH(CW), .APPR_TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
    .entry_pc(entry_pc), .word_count(word_count), .s_data(s_data),
    .s_valid(s_valid), .s_ready(s_ready), .dma_appr(dma_appr),
    .dma_req(dma_req), .cpu_rst(cpu_rst), .we_out(we_out),
    .mar_incr(mar_incr), .dma_data(dma_data), .busy(busy), .done(done),
    .err(err)
  );

  typedef struct {
    logic [2:0]  we;
    logic        incr;
    logic [15:0] data;
  } cmd_t;

  typedef struct {
    logic [15:0] base;
    logic [15:0] pc;
    logic [15:0] w0;
    logic [15:0] step;
    int          count;
    int          stall_idx;
    int          stall_len;
    int          drop_idx;
    bit          restart;
    bit          exp_err;
  } vec_t;

  cmd_t        exp_q[$];
  vec_t        vecs[6];
  int          total = 0;
  int          bad = 0;
  int          done_cnt = 0;
  logic        gap_pend = 1'b0;
  logic [15:0] last_data = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  // Command monitor: every command must match the scoreboard head and be
  // followed by a quiet GAP cycle with unchanged dma_data.
  always @(negedge clk) begin
    cmd_t e;
    if (rst) begin
      gap_pend = 1'b0;
    end else begin
      if (done) done_cnt++;
      if (we_out != WE_NONE || mar_incr) begin
        check("cmd_without_gap", {31'd0, gap_pend}, 32'd0);
        if (exp_q.size() == 0) begin
          check("unexpected_cmd", {12'd0, we_out, mar_incr, dma_data}, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("cmd_we", {29'd0, we_out}, {29'd0, e.we});
          check("cmd_incr", {31'd0, mar_incr}, {31'd0, e.incr});
          check("cmd_data", {16'd0, dma_data}, {16'd0, e.data});
        end
        gap_pend  = 1'b1;
        last_data = dma_data;
      end else if (gap_pend) begin
        check("gap_data_stable", {16'd0, dma_data}, {16'd0, last_data});
        gap_pend = 1'b0;
      end
    end
  end

  function automatic logic [25:0] all_outs();
    return {s_ready, dma_req, cpu_rst, we_out, mar_incr, dma_data, busy, done, err};
  endfunction

  task automatic push_cmd(input logic [2:0] we, input logic incr, input logic [15:0] d);
    cmd_t c;
    c.we = we; c.incr = incr; c.data = d;
    exp_q.push_back(c);
  endtask

  task automatic pulse_start(input logic [15:0] b, input logic [15:0] p, input int n);
    @(negedge clk);
    base_addr  = b;
    entry_pc   = p;
    word_count = 16'(n);
    start      = 1'b1;
    @(negedge clk);
    start      = 1'b0;
  endtask

  // Wait (bounded) for s_ready at a negedge.
  task automatic wait_ready(output bit seen);
    seen = 1'b0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (s_ready) begin
        seen = 1'b1;
        break;
      end
    end
    check("s_ready_seen", {31'd0, seen}, 32'd1);
  endtask

  task automatic run_load(input vec_t v);
    int          dc0;
    bit          seen;
    logic        prev_req;
    logic        prev_rst;
    logic [15:0] w;

    push_cmd(WE_MAR, 1'b0, v.base);
    for (int i = 0; i < v.count; i++) begin
      if (i == v.drop_idx) break;
      w = 16'(v.w0 + v.step * 16'(i));
      push_cmd(WE_RAM, 1'b0, w);
      push_cmd(WE_NONE, 1'b1, 16'h0000);
    end
    if (v.drop_idx < 0) push_cmd(WE_PC, 1'b0, v.pc);
    dc0 = done_cnt;

    pulse_start(v.base, v.pc, v.count);
    check("busy_after_start", {31'd0, busy}, 32'd1);
    check("req_after_start", {30'd0, dma_req, cpu_rst}, 32'd3);
    @(negedge clk);
    dma_appr = 1'b1;

    for (int i = 0; i < v.count; i++) begin
      wait_ready(seen);
      if (!seen) break;
      if (i == v.drop_idx) begin
        dma_appr = 1'b0;
        break;
      end
      if (v.restart && i == 1) begin
        base_addr  = 16'hDEAD;
        entry_pc   = 16'hDEAD;
        word_count = 16'd7;
        start      = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("ready_after_ignored_start", {31'd0, s_ready}, 32'd1);
      end
      if (i == v.stall_idx) begin
        repeat (v.stall_len) @(negedge clk);
        check("stall_ready_held", {31'd0, s_ready}, 32'd1);
        check("stall_no_cmd", {28'd0, we_out, mar_incr}, 32'd0);
      end
      s_data  = 16'(v.w0 + v.step * 16'(i));
      s_valid = 1'b1;
      @(posedge clk);
      #1;
      s_valid = 1'b0;
      s_data  = '0;
    end

    prev_req = dma_req;
    prev_rst = cpu_rst;
    seen     = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        break;
      end
      prev_req = dma_req;
      prev_rst = cpu_rst;
    end
    check("done_seen", {31'd0, seen}, 32'd1);
    check("release_req_rst", {30'd0, prev_req, prev_rst}, 32'd1);
    check("finish_req_rst", {30'd0, dma_req, cpu_rst}, 32'd0);
    check("err_at_done", {31'd0, err}, {31'd0, v.exp_err});
    dma_appr = 1'b0;
    @(negedge clk);
    check("idle_done_busy", {30'd0, done, busy}, 32'd0);
    check("err_held", {31'd0, err}, {31'd0, v.exp_err});
    check("done_pulses", done_cnt - dc0, 32'd1);
    check("scoreboard_empty", exp_q.size(), 32'd0);
    exp_q.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1);
  end

  initial begin
    int  n;
    bit  seen;

    vecs[0] = '{16'h0040, 16'h0040, 16'h1111, 16'h1111, 3, -1, 0, -1, 1'b0, 1'b0};
    vecs[1] = '{16'h0040, 16'h0040, 16'h1111, 16'h1111, 3,  1, 5, -1, 1'b0, 1'b0};
    vecs[2] = '{16'h0200, 16'h0100, 16'h0000, 16'h0000, 0, -1, 0, -1, 1'b0, 1'b0};
    vecs[3] = '{16'h0080, 16'h0080, 16'h1111, 16'h1111, 3, -1, 0,  1, 1'b0, 1'b1};
    vecs[4] = '{16'h1000, 16'hBEEF, 16'hA5A5, 16'h0101, 2, -1, 0, -1, 1'b1, 1'b0};
    vecs[5] = '{16'hFFFF, 16'h0000, 16'hFFFF, 16'h0000, 1, -1, 0, -1, 1'b0, 1'b0};

    rst = 1'b1; start = 1'b0; base_addr = '0; entry_pc = '0; word_count = '0;
    s_data = '0; s_valid = 1'b0; dma_appr = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_outputs", {6'd0, all_outs()}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_outputs", {6'd0, all_outs()}, 32'd0);

    for (int i = 0; i < 3; i++) run_load(vecs[i]);

    // Approval never arrives.
    pulse_start(16'h0400, 16'h0400, 2);
    n = 0;
    while (dma_req && n < 100) begin
      n++;
      @(negedge clk);
    end
    check("timeout_req_cycles", n, TO);
    check("timeout_release", {29'd0, dma_req, cpu_rst, err}, 32'd3);
    @(negedge clk);
    check("timeout_finish", {29'd0, done, err, cpu_rst}, 32'd6);
    @(negedge clk);
    check("timeout_err_held", {30'd0, err, busy}, 32'd2);

    run_load(vecs[3]);

    // Reset in the middle of a RAM write.
    push_cmd(WE_MAR, 1'b0, 16'h0300);
    push_cmd(WE_RAM, 1'b0, 16'h5A5A);
    pulse_start(16'h0300, 16'h0300, 2);
    @(negedge clk);
    dma_appr = 1'b1;
    wait_ready(seen);
    s_data  = 16'h5A5A;
    s_valid = 1'b1;
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (we_out == WE_RAM) begin
        seen = 1'b1;
        break;
      end
    end
    check("reached_wr_ram", {31'd0, seen}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check("midload_reset_outputs", {6'd0, all_outs()}, 32'd0);
    rst = 1'b0;
    dma_appr = 1'b0;
    exp_q.delete();

    for (int i = 4; i < 6; i++) run_load(vecs[i]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
